// File: rtl/pipeline_run_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_run_controller_if
//   Groups the run-control request, the core's write-back retire stream and the
//   controller's status outputs into one bundle.
//
//   Signals
//     start        : one-cycle pulse that begins or restarts a run
//     wb_valid     : core retired an instruction in WB this cycle
//     wb_instr     : instruction retiring in WB, qualified by wb_valid
//     core_reset   : drives the core's reset port
//     running      : core is executing (RUN or DRAIN)
//     done         : run finished, sticky until next start or reset
//     halted       : run ended by HALT
//     timeout      : run ended by cycle budget
//     cycle_count  : cycles spent in RUN plus DRAIN
//     retire_count : instructions retired, HALT included
//     state        : controller state (IDLE=0, RSTH=1, RUN=2, DRAIN=3, DONE=4)
//
//   Modports
//     master : the environment driving start and the retire stream
//     slave  : the controller itself
// -----------------------------------------------------------------------------
interface pipeline_run_controller_if #(
   parameter int CNT_W   = 32,
   parameter int INSTR_W = 32
);
   logic               start;
   logic               wb_valid;
   logic [INSTR_W-1:0] wb_instr;
   logic               core_reset;
   logic               running;
   logic               done;
   logic               halted;
   logic               timeout;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   retire_count;
   logic [2:0]         state;

   modport master (
      output start, wb_valid, wb_instr,
      input  core_reset, running, done, halted, timeout,
      input  cycle_count, retire_count, state
   );

   modport slave (
      input  start, wb_valid, wb_instr,
      output core_reset, running, done, halted, timeout,
      output cycle_count, retire_count, state
   );
endinterface

// File: rtl/pipeline_run_controller.sv
// -----------------------------------------------------------------------------
// pipeline_run_controller
//   Run-control and watchdog wrapper for the MIPS32 pipeline core. Holds the
//   core in reset, releases it for a run, counts cycles and retired
//   instructions, and ends the run either when a HALT word retires in WB
//   (followed by a short drain) or when the RUN cycle budget expires.
//   The run can be restarted from IDLE or DONE with a start pulse.
//
//   Ports
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high controller reset
//     bus    : slave side of pipeline_run_controller_if (start, retire stream,
//              core_reset, status flags, counters, state)
// -----------------------------------------------------------------------------
module pipeline_run_controller #(
   parameter int                 RESET_CYCLES = 2,
   parameter int                 MAX_CYCLES   = 30,
   parameter int                 DRAIN_CYCLES = 3,
   parameter int                 CNT_W        = 32,
   parameter int                 INSTR_W      = 32,
   parameter logic [INSTR_W-1:0] HALT_WORD    = INSTR_W'(32'hFC00_0000)
) (
   input  logic                       clk,
   input  logic                       reset,
   pipeline_run_controller_if.slave   bus
);

   // Phase counters only need to reach PARAM-1.
   localparam int RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int RUN_W   = (MAX_CYCLES   > 1) ? $clog2(MAX_CYCLES)   : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RSTH  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next_state;

   logic [RST_W-1:0]     r_rst_cnt;
   logic [RUN_W-1:0]     r_run_cnt;
   logic [DRAIN_W-1:0]   r_drain_cnt;

   logic                 r_core_reset;
   logic                 r_running;
   logic                 r_done;
   logic                 r_halted;
   logic                 r_timeout;
   logic [CNT_W-1:0]     r_cycle_count;
   logic [CNT_W-1:0]     r_retire_count;

   logic                 w_start_ok;
   logic                 w_halt;
   logic                 w_budget_end;
   logic                 w_rst_end;
   logic                 w_drain_end;
   logic                 w_next_active;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      w_start_ok   = 1'b0;
      w_next_state = r_state;
      w_halt       = bus.wb_valid && (bus.wb_instr == HALT_WORD);
      // The budget uses its own counter so it still fires when the visible
      // cycle_count has saturated at a narrow CNT_W.
      w_budget_end = (r_run_cnt == RUN_W'(MAX_CYCLES - 1));
      w_rst_end    = (r_rst_cnt == RST_W'(RESET_CYCLES - 1));
      w_drain_end  = (r_drain_cnt == DRAIN_W'(DRAIN_LAST));

      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_start_ok   = 1'b1;
               w_next_state = S_RSTH;
            end
         end
         S_RSTH: begin
            if (w_rst_end) w_next_state = S_RUN;
         end
         S_RUN: begin
            // HALT takes priority over a budget expiry on the same edge.
            if (w_halt)
               w_next_state = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
            else if (w_budget_end)
               w_next_state = S_DONE;
         end
         S_DRAIN: begin
            if (w_drain_end) w_next_state = S_DONE;
         end
         default: w_next_state = S_IDLE;
      endcase

      w_next_active = (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // ---------------------------------------------------------------------------
   // Phase counters, counters, flags and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rst_cnt      <= '0;
         r_run_cnt      <= '0;
         r_drain_cnt    <= '0;
         r_core_reset   <= 1'b1;
         r_running      <= 1'b0;
         r_done         <= 1'b0;
         r_halted       <= 1'b0;
         r_timeout      <= 1'b0;
         r_cycle_count  <= '0;
         r_retire_count <= '0;
      end else begin
         // Outputs are registered from the next state so they line up with
         // the state output on the same edge.
         r_core_reset <= !w_next_active;
         r_running    <= w_next_active;
         r_done       <= (w_next_state == S_DONE);

         // Each phase counter runs only while in its own state, so it is
         // already zero on entry.
         r_rst_cnt   <= (r_state == S_RSTH)  ? r_rst_cnt + RST_W'(1)     : '0;
         r_run_cnt   <= (r_state == S_RUN)   ? r_run_cnt + RUN_W'(1)     : '0;
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;

         if (w_start_ok) begin
            r_halted       <= 1'b0;
            r_timeout      <= 1'b0;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
         end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
            if (r_cycle_count != '1)
               r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (bus.wb_valid && (r_retire_count != '1))
               r_retire_count <= r_retire_count + CNT_W'(1);
            if (r_state == S_RUN) begin
               if (w_halt)            r_halted  <= 1'b1;
               else if (w_budget_end) r_timeout <= 1'b1;
            end
         end
      end
   end

   assign bus.state        = r_state;
   assign bus.core_reset   = r_core_reset;
   assign bus.running      = r_running;
   assign bus.done         = r_done;
   assign bus.halted       = r_halted;
   assign bus.timeout      = r_timeout;
   assign bus.cycle_count  = r_cycle_count;
   assign bus.retire_count = r_retire_count;

endmodule
